exe_cond_unit: RTL

- Execute-stage conditional-execution unit, fed directly by the decode-to-execute pipeline register.
- Holds the architectural NZCV flags register and evaluates the 4-bit ARM condition field of the instruction in Execute against it.
- Gates the register-write, memory-write, PC-write and branch controls passed to the execute-to-memory register.
- Updates NZCV from the ALU or shifter result when the instruction executes and requests a flag write.

---
 rtl/arm_pkg.sv | 32 +++
 rtl/exe_cond_unit_if.sv | 38 +++
 rtl/exe_cond_unit_cond_check.sv | 40 ++++
 rtl/exe_cond_unit.sv | 98 +++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ARM execute-stage definitions: condition codes and NZCV bit positions.
// Used by the conditional-execution unit and its condition checker.
package arm_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/exe_cond_unit_if.sv
// Decode-to-execute controls in, gated execute-to-memory controls out.
// valid_e marks a real instruction; there is no ready: Execute consumes every valid cycle.
interface exe_cond_unit_if;
  logic       valid_e;
  logic [3:0] cond_e;
  logic [1:0] flag_w_e;
  logic [3:0] alu_flags_e;
  logic       carry_src_e;
  logic       shift_carry_e;
  logic       pcs_e;
  logic       reg_w_e;
  logic       mem_w_e;
  logic       branch_e;
  logic       branch_link_e;

  logic       cond_ex_e;
  logic       pcs_g;
  logic       reg_w_g;
  logic       mem_w_g;
  logic       branch_taken_e;
  logic       link_w_g;
  logic [3:0] flags_q;
  logic       carry_in_e;

  modport master (
    output valid_e, cond_e, flag_w_e, alu_flags_e, carry_src_e, shift_carry_e,
           pcs_e, reg_w_e, mem_w_e, branch_e, branch_link_e,
    input  cond_ex_e, pcs_g, reg_w_g, mem_w_g, branch_taken_e, link_w_g,
           flags_q, carry_in_e
  );

  modport slave (
    input  valid_e, cond_e, flag_w_e, alu_flags_e, carry_src_e, shift_carry_e,
           pcs_e, reg_w_e, mem_w_e, branch_e, branch_link_e,
    output cond_ex_e, pcs_g, reg_w_g, mem_w_g, branch_taken_e, link_w_g,
           flags_q, carry_in_e
  );
endinterface

// File: rtl/exe_cond_unit_cond_check.sv
// Combinational ARM condition evaluator: 4-bit condition field + NZCV -> pass.
// Kept standalone so the hazard unit can reuse it.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b1;
    case (cond_t'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      // NV is executed unconditionally on this core, same as AL.
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/exe_cond_unit.sv
// Execute-stage conditional-execution unit: holds NZCV, gates write/branch controls.
// Optional performance counters are built when COND_PERF_CNT_EN is defined.
module exe_cond_unit
  import arm_pkg::*;
#(
  parameter logic [3:0] FLAG_RST = 4'b0000
`ifdef COND_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic                clk,
  input  logic                reset,
  exe_cond_unit_if.slave      bus
`ifdef COND_PERF_CNT_EN
  ,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    exec_cnt,
  output logic [CNT_W-1:0]    squash_cnt
`endif
);

  logic [3:0] flags_q, flags_d;
  logic       pass;
  logic       cond_ex;

  // Gating always looks at the registered flags, so an instruction that
  // writes flags is itself judged on the pre-update value.
  cond_check u_cond_check (
    .cond (bus.cond_e),
    .nzcv (flags_q),
    .pass (pass)
  );

  assign cond_ex = bus.valid_e & pass;

  assign bus.cond_ex_e      = cond_ex;
  assign bus.pcs_g          = bus.pcs_e & cond_ex;
  assign bus.reg_w_g        = bus.reg_w_e & cond_ex;
  assign bus.mem_w_g        = bus.mem_w_e & cond_ex;
  assign bus.branch_taken_e = bus.branch_e & cond_ex;
  assign bus.link_w_g       = bus.branch_link_e & bus.branch_e & cond_ex;
  assign bus.flags_q        = flags_q;
  assign bus.carry_in_e     = flags_q[FLAG_C];

  always_comb begin
    flags_d = flags_q;
    if (cond_ex) begin
      if (bus.flag_w_e[FLAGW_NZ]) begin
        flags_d[FLAG_N] = bus.alu_flags_e[FLAG_N];
        flags_d[FLAG_Z] = bus.alu_flags_e[FLAG_Z];
      end
      if (bus.flag_w_e[FLAGW_CV]) begin
        flags_d[FLAG_C] = bus.carry_src_e ? bus.shift_carry_e : bus.alu_flags_e[FLAG_C];
        flags_d[FLAG_V] = bus.alu_flags_e[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= FLAG_RST;
    else        flags_q <= flags_d;
  end

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  // Clear wins over increment; both counters stick at all-ones.
  always_comb begin
    exec_cnt_d   = exec_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (cnt_clr) begin
      exec_cnt_d   = '0;
      squash_cnt_d = '0;
    end else begin
      if (cond_ex && (exec_cnt_q != {CNT_W{1'b1}}))
        exec_cnt_d = exec_cnt_q + 1'b1;
      if (bus.valid_e && !pass && (squash_cnt_q != {CNT_W{1'b1}}))
        squash_cnt_d = squash_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exec_cnt_q   <= '0;
      squash_cnt_q <= '0;
    end else begin
      exec_cnt_q   <= exec_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign exec_cnt   = exec_cnt_q;
  assign squash_cnt = squash_cnt_q;
`endif

endmodule
